hps_m_block_fetcher: RTL and testbench

Read-side master for the port-2 interface of the 1024x128 dual-port message RAM. Fetches N consecutive 512-bit SHA-256 message blocks (4 x 128-bit RAM words each) starting at a base word address. Presents each block to the downstream SHA-256 compression core over a valid/ready handshake. Port 1 of the RAM remains with the HPS bus, which writes the message.

---
 rtl/hps_m_block_fetcher_pkg.sv | 9 +
 rtl/hps_m_block_fetcher_if.sv | 29 ++
 rtl/hps_m_block_fetcher_gather.sv | 21 ++
 rtl/hps_m_block_fetcher.sv | 73 +++++++
 tb/tb_hps_m_block_fetcher.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hps_m_block_fetcher_pkg.sv
// hps_m_fetch_pkg: shared states and block geometry for the message-block fetcher
package hps_m_fetch_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, FIN} state_t;
  localparam int WORDS_PER_BLK = 4;
  localparam int WORD_W = 128;
  localparam int BLK_W = 512;
  localparam int IDX_W = $clog2(WORDS_PER_BLK);
  localparam logic [WORD_W/8-1:0] BE_ONES = '1;
endpackage

// File: rtl/hps_m_block_fetcher_if.sv
// hps_m_block_fetcher_if: RAM port-2 read bus plus the block valid/ready stream
interface hps_m_block_fetcher_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128,
  parameter int BLK_W = 512
);
  logic [ADDR_W-1:0] mem_address;
  logic mem_chipselect;
  logic mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [BLK_W-1:0] blk_data;
  logic blk_valid;
  logic blk_ready;
  logic blk_last;
  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input mem_readdata,
    output blk_data, blk_valid, blk_last,
    input blk_ready
  );
  modport slave (
    input mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input blk_data, blk_valid, blk_last,
    output blk_ready
  );
endinterface

// File: rtl/hps_m_block_fetcher_gather.sv
// hps_m_block_gather: four word slots assembled into one block, word 0 in the MSBs
module hps_m_block_gather
  import hps_m_fetch_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic [IDX_W-1:0] idx,
  input  logic [DATA_W-1:0] din,
  output logic [WORDS_PER_BLK*DATA_W-1:0] blk_data
);
  logic [DATA_W-1:0] slot [WORDS_PER_BLK];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int k = 0; k < WORDS_PER_BLK; k++) slot[k] <= '0;
    else if (we) slot[idx] <= din;
  for (genvar g = 0; g < WORDS_PER_BLK; g++) begin : g_pack
    assign blk_data[(WORDS_PER_BLK-1-g)*DATA_W +: DATA_W] = slot[g];
  end
endmodule

// File: rtl/hps_m_block_fetcher.sv
// hps_m_block_fetcher: reads N consecutive 4-word blocks from RAM port 2 and hands them
// downstream over valid/ready; read data arrives one cycle after its address.
module hps_m_block_fetcher
  import hps_m_fetch_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128,
  parameter int CNT_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0] num_blocks,
  output logic busy,
  output logic done,
  hps_m_block_fetcher_if.master bus
);
  state_t state, next;
  logic [ADDR_W-1:0] addr_ptr;
  logic [CNT_W-1:0] remaining;
  logic [IDX_W-1:0] idx, widx;
  logic accept, we;
  assign accept = state == HOLD && bus.blk_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_ptr <= '0;
      remaining <= '0;
      idx <= '0;
    end else begin
      state <= next;
      idx <= state == FETCH ? idx + 1'b1 : '0;
      if (state == IDLE && start && num_blocks != '0) begin
        addr_ptr <= base_addr;
        remaining <= num_blocks;
      end else if (accept) begin
        addr_ptr <= addr_ptr + ADDR_W'(WORDS_PER_BLK);
        remaining <= remaining - 1'b1;
      end
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = !start ? IDLE : num_blocks != '0 ? FETCH : FIN;
      FETCH: next = idx == IDX_W'(WORDS_PER_BLK-1) ? DRAIN : FETCH;
      DRAIN: next = HOLD;
      HOLD:  next = !accept ? HOLD : remaining == CNT_W'(1) ? FIN : FETCH;
      FIN:   next = IDLE;
      default: next = IDLE;
    endcase
  end
  // slot i-1 is written while address i is issued; DRAIN collects the last word
  assign we = (state == FETCH && idx != '0) || state == DRAIN;
  assign widx = state == DRAIN ? IDX_W'(WORDS_PER_BLK-1) : idx - 1'b1;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign bus.mem_chipselect = state == FETCH;
  assign bus.mem_address = state == FETCH ? addr_ptr + ADDR_W'(idx) : '0;
  assign bus.mem_write = 1'b0;
  assign bus.mem_byteenable = BE_ONES;
  assign bus.mem_clken = 1'b1;
  assign bus.blk_valid = state == HOLD;
  assign bus.blk_last = state == HOLD && remaining == CNT_W'(1);
  hps_m_block_gather #(.DATA_W(DATA_W)) u_gather (
    .clk(clk),
    .reset(reset),
    .we(we),
    .idx(widx),
    .din(bus.mem_readdata),
    .blk_data(bus.blk_data)
  );
endmodule

// File: tb/tb_hps_m_block_fetcher.sv
// tb_hps_m_block_fetcher: scoreboard bench with a synchronous RAM model and a block consumer
module tb_hps_m_block_fetcher;
  logic clk = 0;
  logic reset, start;
  logic [9:0] base_addr, num_blocks;
  logic busy, done;
  logic [127:0] ram [1024];
  logic [127:0] rd;
  int tests = 0, fails = 0, done_cnt = 0;
  logic [9:0] addr_q [$];
  logic [511:0] blk_q [$];
  logic last_q [$];
  logic pv = 0, pr = 0, pl = 0;
  logic [511:0] pd = '0;

  hps_m_block_fetcher_if bus ();
  hps_m_block_fetcher dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_chipselect) rd <= ram[bus.mem_address];
  assign bus.mem_readdata = rd;

  function automatic logic [127:0] word(input logic [9:0] a);
    return {16'hA5C3, 6'd0, a, ~{22'd0, a}, 32'h1234_0000 | {22'd0, a}, a, 22'h2AAAAA};
  endfunction

  task automatic push_blocks(input logic [9:0] base, input int n);
    logic [9:0] a;
    for (int b = 0; b < n; b++) begin
      a = base + 10'(4 * b);
      for (int i = 0; i < 4; i++) addr_q.push_back(a + 10'(i));
      blk_q.push_back({word(a), word(a + 10'd1), word(a + 10'd2), word(a + 10'd3)});
      last_q.push_back(b == n - 1);
    end
  endtask

  task automatic flush;
    addr_q.delete();
    blk_q.delete();
    last_q.delete();
  endtask

  task automatic start_op(input logic [9:0] b, input logic [9:0] n);
    @(posedge clk); #1;
    start = 1; base_addr = b; num_blocks = n;
    @(posedge clk); #1;
    start = 0;
  endtask

  // scoreboard: pops expected addresses and blocks as the DUT produces them
  always @(negedge clk) begin
    if (reset) pv = 0;
    else begin
      if (bus.mem_chipselect) begin
        tests++;
        if (addr_q.size() == 0) begin
          fails++; $display("FAIL addr_unexpected: got %0d, required no read", bus.mem_address);
        end else if (bus.mem_address !== addr_q[0]) begin
          fails++; $display("FAIL addr_seq: got %0d, required %0d", bus.mem_address, addr_q[0]);
        end
        if (addr_q.size() != 0) void'(addr_q.pop_front());
      end
      if (bus.blk_valid && bus.blk_ready) begin
        tests++;
        if (blk_q.size() == 0) begin
          fails++; $display("FAIL blk_unexpected: got %h, required no block", bus.blk_data);
        end else begin
          if (bus.blk_data !== blk_q[0] || bus.blk_last !== last_q[0]) begin
            fails++;
            $display("FAIL blk_data: got %h last %b, required %h last %b", bus.blk_data, bus.blk_last, blk_q[0], last_q[0]);
          end
          void'(blk_q.pop_front());
          void'(last_q.pop_front());
        end
      end
      if (pv && !pr) begin
        tests++;
        if (bus.blk_valid !== 1'b1 || bus.blk_data !== pd || bus.blk_last !== pl) begin
          fails++; $display("FAIL hold_stable: got valid %b last %b, required valid 1 last %b, data held", bus.blk_valid, bus.blk_last, pl);
        end
      end
      pv = bus.blk_valid; pr = bus.blk_ready; pd = bus.blk_data; pl = bus.blk_last;
      if (done) done_cnt++;
    end
  end

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({busy, done, bus.blk_valid, bus.blk_last, bus.mem_chipselect} !== 5'b0 || bus.mem_address !== '0 || bus.blk_data !== '0) begin
      fails++; $display("FAIL reset_outputs: got busy %b done %b valid %b cs %b addr %0d, required all 0", busy, done, bus.blk_valid, bus.mem_chipselect, bus.mem_address);
    end
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    tests++;
    if ({busy, done, bus.blk_valid, bus.mem_chipselect} !== 4'b0) begin
      fails++; $display("FAIL reset_idle: got busy %b done %b valid %b cs %b, required 0", busy, done, bus.blk_valid, bus.mem_chipselect);
    end
    tests++;
    if (bus.mem_write !== 1'b0 || bus.mem_clken !== 1'b1 || bus.mem_byteenable !== 16'hFFFF) begin
      fails++; $display("FAIL const_ctrl: got write %b clken %b be %h, required 0 1 ffff", bus.mem_write, bus.mem_clken, bus.mem_byteenable);
    end
  endtask

  task automatic test_single;
    int d0;
    logic [4:0] exp;
    bus.blk_ready = 1;
    push_blocks(10'd5, 1);
    d0 = done_cnt;
    start_op(10'd5, 10'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp = {k <= 4, k == 6, k == 6, k == 7, k <= 7};
      tests++;
      if ({bus.mem_chipselect, bus.blk_valid, bus.blk_last, done, busy} !== exp) begin
        fails++; $display("FAIL single_timing c%0d: got cs/valid/last/done/busy %b, required %b", k, {bus.mem_chipselect, bus.blk_valid, bus.blk_last, done, busy}, exp);
      end
      if (k <= 4) begin
        tests++;
        if (bus.mem_address !== 10'(4 + k)) begin
          fails++; $display("FAIL single_addr c%0d: got %0d, required %0d", k, bus.mem_address, 4 + k);
        end
      end
      if (k == 6) begin
        tests++;
        if (bus.blk_data[511:384] !== word(10'd5)) begin
          fails++; $display("FAIL single_w0: got %h, required %h", bus.blk_data[511:384], word(10'd5));
        end
      end
    end
    tests++;
    if (done_cnt - d0 != 1 || blk_q.size() != 0 || addr_q.size() != 0) begin
      fails++; $display("FAIL single_end: got done %0d left %0d/%0d, required 1 0/0", done_cnt - d0, blk_q.size(), addr_q.size());
    end
  endtask

  task automatic test_backpressure;
    int d0;
    logic ok;
    logic [511:0] hd;
    bus.blk_ready = 0;
    push_blocks(10'd0, 3);
    d0 = done_cnt;
    start_op(10'd0, 10'd3);
    for (int b = 0; b < 3; b++) begin
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        ok = bus.blk_valid;
      end
      tests++;
      if (!ok) begin fails++; $display("FAIL bp_valid_timeout b%0d: got no valid, required valid", b); end
      tests++;
      if (bus.blk_last !== (b == 2)) begin
        fails++; $display("FAIL bp_last b%0d: got %b, required %b", b, bus.blk_last, b == 2);
      end
      hd = bus.blk_data;
      repeat (10) begin
        @(negedge clk);
        tests++;
        if (bus.blk_data !== hd || bus.blk_valid !== 1'b1) begin
          fails++; $display("FAIL bp_hold b%0d: got valid %b data %h, required valid 1 data %h", b, bus.blk_valid, bus.blk_data, hd);
        end
      end
      @(posedge clk); #1 bus.blk_ready = 1;
      @(posedge clk); #1 bus.blk_ready = 0;
    end
    repeat (6) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || blk_q.size() != 0 || addr_q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL bp_end: got done %0d left %0d/%0d busy %b, required 1 0/0 0", done_cnt - d0, blk_q.size(), addr_q.size(), busy);
    end
  endtask

  task automatic test_wrap;
    int d0;
    bus.blk_ready = 1;
    push_blocks(10'd1022, 1);
    d0 = done_cnt;
    start_op(10'd1022, 10'd1);
    repeat (10) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || blk_q.size() != 0 || addr_q.size() != 0) begin
      fails++; $display("FAIL wrap_end: got done %0d left %0d/%0d, required 1 0/0", done_cnt - d0, blk_q.size(), addr_q.size());
    end
  endtask

  task automatic test_zero;
    start_op(10'd7, 10'd0);
    @(negedge clk);
    tests++;
    if ({done, busy, bus.mem_chipselect, bus.blk_valid} !== 4'b1100) begin
      fails++; $display("FAIL zero_fin: got done/busy/cs/valid %b, required 1100", {done, busy, bus.mem_chipselect, bus.blk_valid});
    end
    @(negedge clk);
    tests++;
    if ({done, busy, bus.mem_chipselect, bus.blk_valid} !== 4'b0000) begin
      fails++; $display("FAIL zero_idle: got done/busy/cs/valid %b, required 0000", {done, busy, bus.mem_chipselect, bus.blk_valid});
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    logic ok;
    bus.blk_ready = 0;
    push_blocks(10'd0, 1);
    d0 = done_cnt;
    start_op(10'd0, 10'd1);
    @(posedge clk);
    @(posedge clk); #2 reset = 1;
    #1;
    tests++;
    if ({busy, done, bus.blk_valid, bus.blk_last, bus.mem_chipselect} !== 5'b0 || bus.mem_address !== '0) begin
      fails++; $display("FAIL rst_fetch: got busy %b cs %b addr %0d, required 0 0 0", busy, bus.mem_chipselect, bus.mem_address);
    end
    @(negedge clk);
    @(posedge clk); #1 reset = 0;
    flush();
    push_blocks(10'd8, 1);
    start_op(10'd8, 10'd1);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.blk_valid;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_valid_timeout: got no valid, required valid"); end
    @(posedge clk); #2 reset = 1;
    #1;
    tests++;
    if ({busy, done, bus.blk_valid, bus.blk_last, bus.mem_chipselect} !== 5'b0 || bus.blk_data !== '0) begin
      fails++; $display("FAIL rst_hold: got busy %b valid %b last %b data %h, required all 0", busy, bus.blk_valid, bus.blk_last, bus.blk_data);
    end
    @(negedge clk);
    @(posedge clk); #1 reset = 0;
    flush();
    repeat (5) @(negedge clk);
    tests++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_no_done: got done %0d busy %b, required 0 0", done_cnt - d0, busy);
    end
    test_single();
  endtask

  task automatic test_start_busy;
    int d0;
    logic ok;
    bus.blk_ready = 0;
    push_blocks(10'd16, 1);
    d0 = done_cnt;
    start_op(10'd16, 10'd1);
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.blk_valid;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL busy_valid_timeout: got no valid, required valid"); end
    start_op(10'd100, 10'd2);
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (bus.blk_valid !== 1'b1 || bus.blk_data[511:384] !== word(10'd16)) begin
        fails++; $display("FAIL busy_hold: got valid %b w0 %h, required 1 %h", bus.blk_valid, bus.blk_data[511:384], word(10'd16));
      end
    end
    @(posedge clk); #1 bus.blk_ready = 1;
    @(posedge clk); #1 bus.blk_ready = 0;
    repeat (6) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || blk_q.size() != 0 || addr_q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL busy_end: got done %0d left %0d/%0d busy %b, required 1 0/0 0", done_cnt - d0, blk_q.size(), addr_q.size(), busy);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = word(10'(a));
    reset = 1; start = 0; base_addr = '0; num_blocks = '0; bus.blk_ready = 0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_start_busy();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
